// File: rtl/padbid_link_master.sv
`timescale 1ns/1ps
// Half-duplex single-wire link initiator on one PADBID pad: send a word, release, receive and check the reply.
// Latency: pad driven from the cycle after accept; result pulse HALF+BIT_CYC*(WIDTH+1) cycles after start detect.
// Backpressure: tx_ready is high only in IDLE; tx_valid while busy is ignored and simply held by the host.
module padbid_link_master #(
  parameter int WIDTH       = 8,
  parameter int BIT_CYC     = 4,
  parameter int TURN_CYC    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_err_frame,
  output logic             rx_err_timeout,
  output logic             busy,
  output logic             pad_i,
  output logic             pad_oen,
  input  logic             pad_c
);

  localparam int HALF = BIT_CYC / 2;
  localparam int CMAX = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int BW   = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_START, S_TX_DATA, S_TX_STOP, S_TURN,
    S_RX_WAIT, S_RX_START, S_RX_DATA, S_RX_STOP
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [BW-1:0]    bit_idx, bit_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [WIDTH-1:0] tx_word, word_n, tx_shr;
  logic [WIDTH-1:0] rx_shift, shift_n, rxd_n;
  logic             c_meta, c_s;
  logic             pad_i_n, pad_oen_n, v_n, fe_n, to_n;

  // next data bit to put on the line once the current one has been held long enough
  assign tx_shr = tx_word >> 1;

  // pad input synchroniser, idles high like the pulled-up line
  always_ff @(posedge CK) begin
    if (!RN) begin
      c_meta <= 1'b1;
      c_s    <= 1'b1;
    end else begin
      c_meta <= pad_c;
      c_s    <= c_meta;
    end
  end

  // next-state and next-output decode; every output is registered from these
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_n     = bit_idx;
    tcnt_n    = tcnt;
    word_n    = tx_word;
    shift_n   = rx_shift;
    rxd_n     = rx_data;
    pad_i_n   = 1'b1;
    pad_oen_n = 1'b1;
    v_n       = 1'b0;
    fe_n      = 1'b0;
    to_n      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (tx_valid && tx_ready) begin
          word_n    = tx_data;
          state_n   = S_TX_START;
          pad_oen_n = 1'b0;
          pad_i_n   = 1'b0;
        end
      end
      S_TX_START: begin
        pad_oen_n = 1'b0;
        pad_i_n   = 1'b0;
        if (cnt == CW'(BIT_CYC - 1)) begin
          state_n = S_TX_DATA;
          cnt_n   = '0;
          bit_n   = '0;
          pad_i_n = tx_word[0];
        end
      end
      S_TX_DATA: begin
        pad_oen_n = 1'b0;
        pad_i_n   = tx_word[0];
        if (cnt == CW'(BIT_CYC - 1)) begin
          cnt_n = '0;
          if (bit_idx == BW'(WIDTH - 1)) begin
            state_n = S_TX_STOP;
            pad_i_n = 1'b1;
          end else begin
            bit_n   = bit_idx + BW'(1);
            word_n  = tx_shr;
            pad_i_n = tx_shr[0];
          end
        end
      end
      S_TX_STOP: begin
        pad_oen_n = 1'b0;
        if (cnt == CW'(BIT_CYC - 1)) begin
          state_n   = S_TURN;
          cnt_n     = '0;
          pad_oen_n = 1'b1;
        end
      end
      S_TURN: begin
        // the line is settling back to the pull-up, so c_s is not looked at here
        if (cnt == CW'(TURN_CYC - 1)) begin
          state_n = S_RX_WAIT;
          cnt_n   = '0;
          tcnt_n  = '0;
        end
      end
      S_RX_WAIT: begin
        cnt_n = '0;
        if (!c_s) begin
          state_n = S_RX_START;
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          to_n    = 1'b1;
          state_n = S_IDLE;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      S_RX_START: begin
        // a start bit must still be low at its midpoint, otherwise it was a glitch
        if (cnt == CW'(HALF - 1)) begin
          cnt_n = '0;
          if (!c_s) begin
            state_n = S_RX_DATA;
            bit_n   = '0;
          end else begin
            state_n = S_RX_WAIT;
          end
        end
      end
      S_RX_DATA: begin
        if (cnt == CW'(BIT_CYC - 1)) begin
          cnt_n            = '0;
          shift_n          = rx_shift >> 1;
          shift_n[WIDTH-1] = c_s;
          if (bit_idx == BW'(WIDTH - 1)) begin
            state_n = S_RX_STOP;
          end else begin
            bit_n = bit_idx + BW'(1);
          end
        end
      end
      S_RX_STOP: begin
        if (cnt == CW'(BIT_CYC - 1)) begin
          rxd_n   = rx_shift;
          v_n     = c_s;
          fe_n    = !c_s;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge CK) begin
    if (!RN) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      tcnt           <= '0;
      tx_word        <= '0;
      rx_shift       <= '0;
      rx_data        <= '0;
      tx_ready       <= 1'b0;
      busy           <= 1'b0;
      rx_valid       <= 1'b0;
      rx_err_frame   <= 1'b0;
      rx_err_timeout <= 1'b0;
      pad_i          <= 1'b1;
      pad_oen        <= 1'b1;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_n;
      tcnt           <= tcnt_n;
      tx_word        <= word_n;
      rx_shift       <= shift_n;
      rx_data        <= rxd_n;
      tx_ready       <= (state_n == S_IDLE);
      busy           <= (state_n != S_IDLE);
      rx_valid       <= v_n;
      rx_err_frame   <= fe_n;
      rx_err_timeout <= to_n;
      pad_i          <= pad_i_n;
      pad_oen        <= pad_oen_n;
    end
  end

endmodule

// File: tb/tb_padbid_link_master.sv
`timescale 1ns/1ps
// Bench for padbid_link_master: random words and replies against a frame-level reference model.
// Latency: results are matched in order by a monitor against expectations queued at issue time.
// Backpressure: the host holds tx_valid until busy shows the word was taken.
module tb_padbid_link_master;
  localparam int WIDTH = 8, BIT_CYC = 4, TURN_CYC = 2, TIMEOUT_CYC = 64;
  localparam int FRAME_CYC = (WIDTH + 2) * BIT_CYC;

  logic             CK = 1'b0;
  logic             RN = 1'b0;
  logic             tx_valid = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_ready, rx_valid, rx_err_frame, rx_err_timeout, busy, pad_i, pad_oen;
  logic [WIDTH-1:0] rx_data;
  logic             pad_c;
  logic             resp_oe = 1'b0;
  logic             resp_val = 1'b1;

  // pad line: master drives when OEN low, else responder, else pull-up
  assign pad_c = !pad_oen ? pad_i : (resp_oe ? resp_val : 1'b1);

  padbid_link_master #(.WIDTH(WIDTH), .BIT_CYC(BIT_CYC), .TURN_CYC(TURN_CYC),
                       .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CK(CK), .RN(RN), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err_frame(rx_err_frame),
    .rx_err_timeout(rx_err_timeout), .busy(busy), .pad_i(pad_i), .pad_oen(pad_oen),
    .pad_c(pad_c)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int               kind;   // 1 good reply, 2 frame error, 3 timeout
    logic [WIDTH-1:0] data;
    int               min_lat;
    int               max_lat;
  } exp_t;

  exp_t             exp_rx[$];
  logic [WIDTH-1:0] exp_tx[$];
  logic [WIDTH-1:0] model_rx = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // monitor: checks every transmitted frame and every result pulse
  logic             prev_oen = 1'b1;
  logic             cap[$];
  int               rel_cyc = 0;
  logic [63:0]      gotv, expv;
  logic [WIDTH-1:0] tw;
  exp_t             e;
  int               kind, lat, b;
  always @(negedge CK) begin
    if (!RN) begin
      cap.delete();
      prev_oen = 1'b1;
    end else begin
      if (!pad_oen) cap.push_back(pad_i);
      if (pad_oen && !prev_oen) begin
        rel_cyc = cyc;
        if (exp_tx.size() == 0) begin
          bound_fail("tx_unexpected_frame");
        end else begin
          tw = exp_tx.pop_front();
          gotv = '0;
          expv = '0;
          for (int i = 0; i < FRAME_CYC; i++) begin
            b = i / BIT_CYC;
            expv[i] = (b == 0) ? 1'b0 : (b == WIDTH + 1) ? 1'b1 : tw[b-1];
          end
          for (int i = 0; i < cap.size() && i < 64; i++) gotv[i] = cap[i];
          chk("tx_drive_len", cap.size(), FRAME_CYC);
          chk("tx_bits", gotv[31:0], expv[31:0]);
          chk("tx_bits_hi", gotv[63:32], expv[63:32]);
        end
        cap.delete();
      end
      prev_oen = pad_oen;
      if (rx_valid || rx_err_frame || rx_err_timeout) begin
        chk("result_onehot", int'(rx_valid) + int'(rx_err_frame) + int'(rx_err_timeout), 1);
        if (exp_rx.size() == 0) begin
          bound_fail("result_unexpected");
        end else begin
          e = exp_rx.pop_front();
          kind = rx_valid ? 1 : (rx_err_frame ? 2 : 3);
          lat = cyc - rel_cyc;
          chk("result_kind", kind, e.kind);
          chk("result_rx_data", rx_data, e.data);
          checks++;
          if (lat < e.min_lat || lat > e.max_lat) begin
            failures++;
            $display("FAIL result_latency: got=%0d expected=[%0d..%0d]", lat, e.min_lat, e.max_lat);
          end
        end
      end
    end
  end

  // responder: one frame with the given stop bit, bits change just after a rising edge
  task automatic respond(input logic [WIDTH-1:0] w, input logic stop);
    for (int i = 0; i < WIDTH + 2; i++) begin
      resp_oe  = 1'b1;
      resp_val = (i == 0) ? 1'b0 : (i == WIDTH + 1) ? stop : w[i-1];
      repeat (BIT_CYC) tick();
    end
    resp_oe  = 1'b0;
    resp_val = 1'b1;
  endtask

  // one transaction; mode 0 good reply, 1 bad stop bit, 2 no reply
  task automatic xact(input logic [WIDTH-1:0] w, input int mode, input logic [WIDTH-1:0] rw,
                      input int d, input bit glitch);
    exp_t x;
    int   n;
    int   extra;
    extra = glitch ? 7 : 0;
    exp_tx.push_back(w);
    if (mode == 2) begin
      x.kind    = 3;
      x.data    = model_rx;
      x.min_lat = TURN_CYC + TIMEOUT_CYC;
      // a rejected false start costs a few uncounted cycles in the start check
      x.max_lat = TURN_CYC + TIMEOUT_CYC + (glitch ? BIT_CYC / 2 + 3 : 0);
    end else begin
      x.kind    = (mode == 0) ? 1 : 2;
      x.data    = rw;
      model_rx  = rw;
      // 2 sync stages + 1 detect + half bit + WIDTH data bits + stop bit
      x.min_lat = d + extra + 3 + BIT_CYC / 2 + BIT_CYC * (WIDTH + 1);
      x.max_lat = x.min_lat;
    end
    exp_rx.push_back(x);
    tx_data  = w;
    tx_valid = 1'b1;
    n = 0;
    while (!busy && n < 50) begin tick(); n++; end
    tx_valid = 1'b0;
    tx_data  = WIDTH'($urandom);
    if (!busy) begin bound_fail("accept_wait"); return; end
    n = 0;
    while (!pad_oen && n < FRAME_CYC + 10) begin tick(); n++; end
    if (!pad_oen) begin bound_fail("release_wait"); return; end
    repeat (d) tick();
    if (glitch) begin
      resp_oe  = 1'b1;
      resp_val = 1'b0;
      tick();
      resp_oe  = 1'b0;
      resp_val = 1'b1;
      repeat (6) tick();
    end
    if (mode != 2) respond(rw, mode == 0);
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    if (busy) bound_fail("idle_wait");
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pad_oen"}, pad_oen, 1'b1);
    chk({tag, "_pad_i"}, pad_i, 1'b1);
    chk({tag, "_tx_ready"}, tx_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pulses"}, {rx_valid, rx_err_frame, rx_err_timeout}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    RN = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("por");
    chk("por_rx_data", rx_data, 8'h00);
    RN = 1'b1;
    tick();
    chk("por_tx_ready_after_release", tx_ready, 1'b1);

    xact(8'hA5, 0, 8'h3C, 5, 1'b0);
    xact(8'h5A, 2, 8'h00, 0, 1'b0);
    xact(8'hC3, 2, 8'h00, 4, 1'b1);
    xact(8'h0F, 1, 8'h81, 7, 1'b0);
    xact(8'hF0, 2, 8'h00, 0, 1'b0);
    xact(8'h96, 0, 8'h69, 3, 1'b1);

    // reset while idle
    repeat (2) tick();
    RN = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("idle_rst");
    chk("idle_rst_rx_data", rx_data, 8'h00);
    model_rx = '0;
    RN = 1'b1;
    tick();
    chk("idle_rst_tx_ready_after_release", tx_ready, 1'b1);

    // reset in the middle of data bit 3 with the request still held
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!busy && n < 50) begin tick(); n++; end
    end
    repeat (17) tick();
    chk("midtx_pad_driven", pad_oen, 1'b0);
    RN = 1'b0;
    tick();
    chk_reset_outputs("midtx_rst");
    tick();
    RN = 1'b1;
    xact(8'h5A, 0, 8'hE7, 2, 1'b0);

    for (int t = 0; t < 14; t++) begin
      mode = $urandom_range(0, 9);
      mode = (mode < 7) ? 0 : (mode < 9) ? 1 : 2;
      xact(WIDTH'($urandom), mode, WIDTH'($urandom), $urandom_range(1, 20), 1'b0);
    end

    repeat (3) tick();
    chk("exp_rx_drained", exp_rx.size(), 0);
    chk("exp_tx_drained", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
